// File: rtl/bitscan_encoder.sv
// bitscan_encoder: accepts a WIDTH-bit request vector and serialises its set
// bits as handshaked beats (binary index + one-hot), in priority order.
// An all-zero vector yields a single beat flagged with out_zero.
module bitscan_encoder #(
   parameter int WIDTH     = 8,
   parameter bit PRIO_HIGH = 1'b0,
   localparam int IDXW     = $clog2(WIDTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_vec,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IDXW-1:0]   out_idx,
   output logic [WIDTH-1:0]  out_onehot,
   output logic [IDXW:0]     out_seq,
   output logic              out_last,
   output logic              out_zero
);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  pending_q, pending_d;
   logic [IDXW:0]     seq_q, seq_d;
   logic              zero_q, zero_d;

   logic              sel_found;
   logic [IDXW-1:0]   sel_idx;
   logic [WIDTH-1:0]  sel_onehot;
   logic              sel_last;
   logic              scan;

   // State registers: async reset discards any in-flight vector.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= '0;
         seq_q     <= '0;
         zero_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         seq_q     <= seq_d;
         zero_q    <= zero_d;
      end
   end

   // Priority select over pending: the last match in scan order wins, so
   // scanning low-to-high picks the highest bit and high-to-low the lowest.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int unsigned k = 0; k < WIDTH; k++) begin
         int unsigned b;
         b = PRIO_HIGH ? k : (WIDTH - 1 - k);
         if (pending_q[b]) begin
            sel_found = 1'b1;
            sel_idx   = IDXW'(b);
         end
      end
      sel_onehot = sel_found ? (WIDTH'(1) << sel_idx) : '0;
      sel_last   = ((pending_q & ~sel_onehot) == '0);
   end

   // Next-state logic: load on accept, retire one selected bit per beat.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      seq_d     = seq_q;
      zero_d    = zero_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               pending_d = in_vec;
               seq_d     = '0;
               zero_d    = (in_vec == '0);
               state_d   = SCAN;
            end
         end
         SCAN: begin
            if (out_ready) begin
               pending_d = pending_q & ~sel_onehot;
               if (sel_last) begin
                  seq_d   = '0;
                  zero_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  seq_d = seq_q + (IDXW+1)'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from registered state only; forced to zero outside SCAN.
   always_comb begin
      scan       = (state_q == SCAN);
      in_ready   = !scan;
      out_valid  = scan;
      out_idx    = scan ? sel_idx    : '0;
      out_onehot = scan ? sel_onehot : '0;
      out_seq    = scan ? seq_q      : '0;
      out_last   = scan && sel_last;
      out_zero   = scan && zero_q;
   end

endmodule

// File: tb/tb_bitscan_encoder.sv
// tb_bitscan_encoder: table-driven check of two WIDTH=8 instances (lowest-
// first and highest-first), plus reset and mid-scan reset sequences.
module tb_bitscan_encoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_vec_valid_lo = 1'b0, in_vec_valid_hi = 1'b0;
   logic [7:0] in_vec = '0;
   logic       out_ready = 1'b1;

   logic       rdy_lo, vld_lo, last_lo, zero_lo;
   logic [2:0] idx_lo;
   logic [7:0] oh_lo;
   logic [3:0] seq_lo;
   logic       rdy_hi, vld_hi, last_hi, zero_hi;
   logic [2:0] idx_hi;
   logic [7:0] oh_hi;
   logic [3:0] seq_hi;

   logic       sel_hi = 1'b0;
   logic       o_rdy, o_vld, o_last, o_zero;
   logic [2:0] o_idx;
   logic [7:0] o_oh;
   logic [3:0] o_seq;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   bitscan_encoder #(.WIDTH(8), .PRIO_HIGH(1'b0)) dut_lo (
      .clk(clk), .rst(rst), .in_valid(in_vec_valid_lo), .in_ready(rdy_lo),
      .in_vec(in_vec), .out_valid(vld_lo), .out_ready(out_ready),
      .out_idx(idx_lo), .out_onehot(oh_lo), .out_seq(seq_lo),
      .out_last(last_lo), .out_zero(zero_lo));

   bitscan_encoder #(.WIDTH(8), .PRIO_HIGH(1'b1)) dut_hi (
      .clk(clk), .rst(rst), .in_valid(in_vec_valid_hi), .in_ready(rdy_hi),
      .in_vec(in_vec), .out_valid(vld_hi), .out_ready(out_ready),
      .out_idx(idx_hi), .out_onehot(oh_hi), .out_seq(seq_hi),
      .out_last(last_hi), .out_zero(zero_hi));

   always_comb begin
      o_rdy  = sel_hi ? rdy_hi  : rdy_lo;
      o_vld  = sel_hi ? vld_hi  : vld_lo;
      o_last = sel_hi ? last_hi : last_lo;
      o_zero = sel_hi ? zero_hi : zero_lo;
      o_idx  = sel_hi ? idx_hi  : idx_lo;
      o_oh   = sel_hi ? oh_hi   : oh_lo;
      o_seq  = sel_hi ? seq_hi  : seq_lo;
   end

   typedef struct {
      logic [7:0]  vec;
      bit          hi;     // use the highest-first instance
      int          nb;     // expected beat count
      logic [31:0] idx;    // expected index of beat k in nibble k
      int          stall;  // beat held with out_ready low for 3 cycles, -1 none
      bit          pulse;  // pulse in_valid during the scan
      bit          zero;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_valid(input bit hi, input logic v);
      if (hi) in_vec_valid_hi = v;
      else    in_vec_valid_lo = v;
   endtask

   task automatic run_vec(input vec_t e);
      int cnt;
      logic [2:0] ei;
      logic [7:0] eoh;
      sel_hi = e.hi;
      cnt = 0;
      @(negedge clk);
      while (!o_rdy && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      chk("ready_before_accept", {31'd0, o_rdy}, 32'd1);
      in_vec = e.vec;
      set_valid(e.hi, 1'b1);
      @(posedge clk); #1;
      set_valid(e.hi, e.pulse && e.nb > 1);
      if (e.pulse) in_vec = 8'h0F;
      for (int k = 0; k < e.nb; k++) begin
         ei  = e.idx[4*k +: 3];
         eoh = e.zero ? 8'h00 : (8'd1 << ei);
         if (k == e.stall) begin
            out_ready = 1'b0;
            for (int s = 0; s < 3; s++) begin
               @(negedge clk);
               chk("stall_valid",  {31'd0, o_vld}, 32'd1);
               chk("stall_idx",    {29'd0, o_idx}, {29'd0, ei});
               chk("stall_onehot", {24'd0, o_oh},  {24'd0, eoh});
               chk("stall_seq",    {28'd0, o_seq}, k);
               @(posedge clk); #1;
            end
            out_ready = 1'b1;
         end
         @(negedge clk);
         chk("beat_valid",  {31'd0, o_vld},  32'd1);
         chk("beat_ready",  {31'd0, o_rdy},  32'd0);
         chk("beat_idx",    {29'd0, o_idx},  {29'd0, ei});
         chk("beat_onehot", {24'd0, o_oh},   {24'd0, eoh});
         chk("beat_seq",    {28'd0, o_seq},  k);
         chk("beat_last",   {31'd0, o_last}, {31'd0, (k == e.nb - 1)});
         chk("beat_zero",   {31'd0, o_zero}, {31'd0, e.zero});
         @(posedge clk); #1;
         set_valid(e.hi, e.pulse && (k + 1 < e.nb - 1) && (k % 2 == 1));
      end
      set_valid(e.hi, 1'b0);
      @(negedge clk);
      chk("done_ready", {31'd0, o_rdy}, 32'd1);
      chk("done_valid", {31'd0, o_vld}, 32'd0);
      @(negedge clk);
      chk("idle_valid", {31'd0, o_vld}, 32'd0);
   endtask

   initial begin
      vec_t e;
      tbl[0] = '{vec: 8'hA4, hi: 0, nb: 3, idx: 32'h00000752, stall: -1, pulse: 0, zero: 0};
      tbl[1] = '{vec: 8'hA4, hi: 0, nb: 3, idx: 32'h00000752, stall: 1,  pulse: 0, zero: 0};
      tbl[2] = '{vec: 8'h00, hi: 0, nb: 1, idx: 32'h00000000, stall: -1, pulse: 0, zero: 1};
      tbl[3] = '{vec: 8'hFF, hi: 1, nb: 8, idx: 32'h01234567, stall: -1, pulse: 1, zero: 0};
      tbl[4] = '{vec: 8'h81, hi: 0, nb: 2, idx: 32'h00000070, stall: -1, pulse: 0, zero: 0};
      tbl[5] = '{vec: 8'h81, hi: 1, nb: 2, idx: 32'h00000007, stall: 0,  pulse: 0, zero: 0};
      tbl[6] = '{vec: 8'h80, hi: 1, nb: 1, idx: 32'h00000007, stall: -1, pulse: 0, zero: 0};
      tbl[7] = '{vec: 8'h00, hi: 1, nb: 1, idx: 32'h00000000, stall: -1, pulse: 0, zero: 1};

      // Reset held 3 cycles with random inputs.
      for (int c = 0; c < 3; c++) begin
         in_vec_valid_lo = 1'($urandom);
         in_vec_valid_hi = 1'($urandom);
         in_vec          = 8'($urandom);
         out_ready       = 1'($urandom);
         @(negedge clk);
         chk("rst_valid_lo", {31'd0, vld_lo}, 32'd0);
         chk("rst_ready_lo", {31'd0, rdy_lo}, 32'd1);
         chk("rst_fields_lo", {idx_lo, oh_lo, seq_lo, last_lo, zero_lo}, 32'd0);
         chk("rst_valid_hi", {31'd0, vld_hi}, 32'd0);
         chk("rst_ready_hi", {31'd0, rdy_hi}, 32'd1);
         chk("rst_fields_hi", {idx_hi, oh_hi, seq_hi, last_hi, zero_hi}, 32'd0);
      end
      in_vec_valid_lo = 1'b0;
      in_vec_valid_hi = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("post_rst_valid", {31'd0, vld_lo | vld_hi}, 32'd0);
      end

      for (int t = 0; t < 8; t++) run_vec(tbl[t]);

      // Reset mid-scan of 8'hF0 after two beats.
      sel_hi = 1'b0;
      @(negedge clk);
      chk("f0_ready", {31'd0, rdy_lo}, 32'd1);
      in_vec = 8'hF0;
      in_vec_valid_lo = 1'b1;
      @(posedge clk); #1;
      in_vec_valid_lo = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("f0_idx", {29'd0, idx_lo}, 4 + k);
         @(posedge clk); #1;
      end
      #2;
      chk("f0_third_valid", {31'd0, vld_lo}, 32'd1);
      rst = 1'b1;
      #1;
      chk("async_rst_valid", {31'd0, vld_lo}, 32'd0);
      chk("async_rst_ready", {31'd0, rdy_lo}, 32'd1);
      chk("async_rst_last",  {31'd0, last_lo}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      e = '{vec: 8'h01, hi: 0, nb: 1, idx: 32'h00000000, stall: -1, pulse: 0, zero: 0};
      run_vec(e);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
